// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 4-requester round-robin arbiter slice.
package rr_arb_pkg;
    localparam int unsigned N_REQ = 4;
    typedef logic [1:0] sel_t;
    typedef logic [7:0] gcnt_t;
endpackage

// File: rtl/rr_pick_4.sv
// Round-robin pick: first asserted request searched from ptr upward, wrapping mod 4.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output logic             any,
    output sel_t             pick
);

    logic found;
    sel_t idx;

    always_comb begin
        any   = |req;
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = sel_t'(ptr + k[1:0]);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4_1.sv
// Round-robin arbiter feeding a registered 4:1 select stage.
// Optional per-requester saturating grant counters under RR_ARB_GRANT_CNT_EN.
module rr_arb_4_1
    import rr_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [WIDTH-1:0]        d0,
    input  logic [WIDTH-1:0]        d1,
    input  logic [WIDTH-1:0]        d2,
    input  logic [WIDTH-1:0]        d3,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output sel_t                    out_sel
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    output gcnt_t [N_REQ-1:0]       grant_cnt
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    sel_t             out_sel_q, out_sel_d;
    sel_t             ptr_q, ptr_d;

    logic             any;
    sel_t             pick;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] pick_data;

    rr_pick_4 u_pick (
        .req  (in_valid),
        .ptr  (ptr_q),
        .any  (any),
        .pick (pick)
    );

    // rst_n gates the load so no requester sees in_ready while reset is held
    assign can_load = !out_valid_q || out_ready;
    assign load     = rst_n && can_load && any;

    always_comb begin
        case (pick)
            2'd0:    pick_data = d0;
            2'd1:    pick_data = d1;
            2'd2:    pick_data = d2;
            default: pick_data = d3;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[pick] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_data;
            out_sel_d   = pick;
            ptr_d       = sel_t'(pick + 2'd1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

`ifdef RR_ARB_GRANT_CNT_EN
    gcnt_t [N_REQ-1:0] gcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gcnt_q <= '0;
        end else if (load && gcnt_q[pick] != '1) begin
            gcnt_q[pick] <= gcnt_q[pick] + 8'd1;
        end
    end

    assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed bench for rr_arb_4_1; grant counter checks run when RR_ARB_GRANT_CNT_EN is defined.
module tb_rr_arb_4_1;
    import rr_arb_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [3:0]       d0, d1, d2, d3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    sel_t             out_sel;
`ifdef RR_ARB_GRANT_CNT_EN
    gcnt_t [3:0]      grant_cnt;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    rr_arb_4_1 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef RR_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
        chk({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        out_ready = 1'b1;

        // 1. reset with all requesters valid
        #1;
        chk("rst.in_ready_comb", 32'(in_ready), 32'h0);
        tick();
        tick();
        chk_out("rst", 1'b0, 2'd0, 4'd0);
        chk("rst.in_ready", 32'(in_ready), 32'h0);

        // 2. all valid, constant drain: 0,1,2,3,0,... then 0,1,2 leaves ptr=3
        rst_n = 1'b1;
        for (int k = 0; k < 11; k++) begin
            #1;
            chk($sformatf("rr%0d.in_ready", k), 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 4'((k % 4) + 1));
        end

        // 3. only requester 2 with ptr=3: search wraps 3,0,1,2
        in_valid = 4'b0100;
        d2 = 4'hA;
        #1;
        chk("wrap.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("wrap", 1'b1, 2'd2, 4'hA);

        // idle drain: valid drops, sel/data kept, ptr must not move
        in_valid = 4'b0000;
        #1;
        chk("idle.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("idle", 1'b0, 2'd2, 4'hA);

        // 4. back-pressure; ptr=3 so requester 3 loads first
        in_valid = 4'b1111;
        d2 = 4'd3;
        #1;
        chk("bp_pre.in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("bp_pre", 1'b1, 2'd3, 4'd4);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'h0);
            tick();
            chk_out($sformatf("bp%0d", k), 1'b1, 2'd3, 4'd4);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("bp_rel", 1'b1, 2'd0, 4'd1);

        // 5. reset mid-stream with ptr=1 and a word held
        rst_n = 1'b0;
        #1;
        chk("mrst.in_ready_comb", 32'(in_ready), 32'h0);
        tick();
        chk_out("mrst", 1'b0, 2'd0, 4'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_rel.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("mrst_rel", 1'b1, 2'd0, 4'd1);

`ifdef RR_ARB_GRANT_CNT_EN
        // 6. saturating grant counters, requester 1 only
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) chk($sformatf("gc_rst%0d", i), 32'(grant_cnt[i]), 32'h0);
        rst_n = 1'b1;
        in_valid = 4'b0010;
        for (int k = 0; k < 254; k++) tick();
        chk("gc_254", 32'(grant_cnt[1]), 32'd254);
        tick();
        chk("gc_255", 32'(grant_cnt[1]), 32'd255);
        for (int k = 0; k < 45; k++) tick();
        chk("gc_sat", 32'(grant_cnt[1]), 32'd255);
        chk("gc_0",   32'(grant_cnt[0]), 32'd0);
        chk("gc_2",   32'(grant_cnt[2]), 32'd0);
        chk("gc_3",   32'(grant_cnt[3]), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("gc_clr", 32'(grant_cnt[1]), 32'd0);
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
